// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_subtractor                                         |
// | Purpose  : bit-serial unsigned A - B, LSB first, one bit per clock   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic               w_a;
  logic               w_b;
  logic               w_d;
  logic               w_br_nxt;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_r_sr;
  logic               r_br;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;

  // Full-subtractor cell operating on the current LSBs and the running borrow.
  assign w_a      = r_a_sr[0];
  assign w_b      = r_b_sr[0];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_last   = (r_cnt == c_last);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Leaving DONE doubles as an accepting edge so a held start
        // sustains one operation every WIDTH+1 cycles.
        if (start_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_r_sr   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= minuend_i;
      r_b_sr <= subtrahend_i;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_r_sr <= {w_d, r_r_sr[WIDTH-1:1]};
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= {w_d, r_r_sr[WIDTH-1:1]};
        r_borrow <= w_br_nxt;
      end
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);
  assign diff_o   = r_diff;
  assign borrow_o = r_borrow;

endmodule

`default_nettype wire
